// File: rtl/audio_fifo_pkg.sv
// Shared constants and helpers for the audio FIFO and related buffering blocks.
package audio_fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // Smallest r such that 2**r >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res = res + 1;
    return res;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write on port A, registered read with enable on port B.
module fifo_dpram #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dob
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dob_q;
  logic [DATA_WIDTH-1:0] dob_d;

  always_ff @(posedge clk) begin
    if (wea) mem_q[addra] <= dia;
  end

  always_comb begin
    dob_d = dob_q;
    if (enb) dob_d = mem_q[addrb];
  end

  // Read register is reset so the output never shows X after reset.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) dob_q <= '0;
    else       dob_q <= dob_d;
  end

  assign dob = dob_q;

endmodule

// File: rtl/audio_fifo.sv
// Audio sample FIFO with standard/FWFT read modes, fill level, thresholds, sticky errors and flush.
module audio_fifo
  import audio_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
  localparam int unsigned LVL_W = clog2(DEPTH + 1);
  localparam bit          SHOW_AHEAD = (FWFT == FWFT_ON);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [LVL_W-1:0]      ram_words;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc, ram_rd, prefetch;

  assign full         = (level_q == LVL_W'(DEPTH));
  assign almost_full  = (level_q >= LVL_W'(AF_LEVEL));
  assign almost_empty = (level_q <= LVL_W'(AE_LEVEL));
  assign empty        = SHOW_AHEAD ? ~valid_q : (level_q == '0);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Words still sitting in the RAM, excluding the one already presented on data_out.
  assign ram_words = level_q - LVL_W'(valid_q);

  always_comb begin
    wr_acc   = wr_en & ~full & ~clr;
    rd_acc   = rd_en & ~empty & ~clr;
    prefetch = SHOW_AHEAD & (ram_words != '0) & (~valid_q | rd_acc) & ~clr;
    ram_rd   = SHOW_AHEAD ? prefetch : rd_acc;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (ram_rd) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (wr_en & full)  ovf_d = 1'b1;
      if (rd_en & empty) udf_d = 1'b1;
      if (SHOW_AHEAD) begin
        if (prefetch)    valid_d = 1'b1;
        else if (rd_acc) valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // In standard mode the RAM read register is data_out; in FWFT mode it holds the prefetched head.
  fifo_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_a (rst_a),
    .wea   (wr_acc),
    .addra (wr_ptr_q),
    .dia   (data_in),
    .enb   (ram_rd),
    .addrb (rd_ptr_q),
    .dob   (data_out)
  );

endmodule

// File: tb/tb_audio_fifo.sv
// Randomised scoreboard bench driving a standard-mode and an FWFT-mode audio_fifo side by side.
module tb_audio_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 4;

  logic        clk;
  logic        rst_a;
  logic        clr    [2];
  logic        wr_en  [2];
  logic        rd_en  [2];
  logic [23:0] din    [2];
  logic [23:0] dout   [2];
  logic        full   [2];
  logic        empty  [2];
  logic        af     [2];
  logic        ae     [2];
  logic [4:0]  lvl    [2];
  logic        ovf    [2];
  logic        udf    [2];

  int tests = 0;
  int fails = 0;

  // Reference model state per instance (0 = standard, 1 = FWFT).
  int          m_lvl  [2];
  bit          m_val  [2];
  bit          m_ovf  [2];
  bit          m_udf  [2];
  logic [23:0] m_last;
  logic [23:0] mq     [2][$];
  logic [23:0] sq     [2][$];
  bit          pend   [2];

  audio_fifo #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_std (
    .clk(clk), .rst_a(rst_a), .clr(clr[0]), .wr_en(wr_en[0]), .data_in(din[0]),
    .rd_en(rd_en[0]), .data_out(dout[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(af[0]), .almost_empty(ae[0]), .level(lvl[0]),
    .overflow(ovf[0]), .underflow(udf[0]));

  audio_fifo #(.DATA_WIDTH(24), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_fwft (
    .clk(clk), .rst_a(rst_a), .clr(clr[1]), .wr_en(wr_en[1]), .data_in(din[1]),
    .rd_en(rd_en[1]), .data_out(dout[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(af[1]), .almost_empty(ae[1]), .level(lvl[1]),
    .overflow(ovf[1]), .underflow(udf[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input int m);
    logic [23:0] e;
    if (sq[m].size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_sb_underrun: got read data %0h expected no read at %0t",
               m ? "fwft" : "std", dout[m], $time);
    end else begin
      e = sq[m].pop_front();
      chk(m ? "fwft_sb_data" : "std_sb_data", 32'(dout[m]), 32'(e));
    end
  endtask

  // Monitor: FWFT head is checked while presented; standard data is checked one edge after the read.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic will;
      if (rst_a) begin
        pend[m] = 1'b0;
      end else begin
        if (m == 0 && pend[0]) pop_cmp(0);
        will = rd_en[m] && !empty[m] && !clr[m];
        if (m == 1 && will) pop_cmp(1);
        if (m == 0) pend[0] = will;
      end
    end
  end

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lvl[m] = 0; m_val[m] = 0; m_ovf[m] = 0; m_udf[m] = 0;
      mq[m].delete(); sq[m].delete();
    end
    m_last = '0;
  endtask

  // Apply the FIFO rules to the inputs that were present at the last edge.
  task automatic model_step(input int m);
    bit is_full, is_empty, wa, ra, pf;
    if (clr[m]) begin
      m_lvl[m] = 0; m_val[m] = 0; m_ovf[m] = 0; m_udf[m] = 0;
      mq[m].delete(); sq[m].delete();
    end else begin
      is_full  = (m_lvl[m] == DEPTH);
      is_empty = (m == 0) ? (m_lvl[m] == 0) : !m_val[m];
      wa = wr_en[m] && !is_full;
      ra = rd_en[m] && !is_empty;
      if (wr_en[m] && is_full)  m_ovf[m] = 1;
      if (rd_en[m] && is_empty) m_udf[m] = 1;
      if (m == 1) begin
        pf = ((m_lvl[1] - int'(m_val[1])) > 0) && (!m_val[1] || ra);
        m_val[1] = pf ? 1'b1 : (ra ? 1'b0 : m_val[1]);
      end
      if (ra) begin
        if (m == 0) m_last = mq[0][0];
        void'(mq[m].pop_front());
      end
      if (wa) begin
        mq[m].push_back(din[m]);
        sq[m].push_back(din[m]);
      end
      m_lvl[m] = m_lvl[m] + int'(wa) - int'(ra);
    end
  endtask

  task automatic check_all(input int m);
    string p;
    p = m ? "fwft" : "std";
    chk({p, "_level"},     32'(lvl[m]),  32'(m_lvl[m]));
    chk({p, "_full"},      32'(full[m]), 32'(m_lvl[m] == DEPTH));
    chk({p, "_empty"},     32'(empty[m]), m ? 32'(!m_val[m]) : 32'(m_lvl[m] == 0));
    chk({p, "_almost_full"},  32'(af[m]), 32'(m_lvl[m] >= AFL));
    chk({p, "_almost_empty"}, 32'(ae[m]), 32'(m_lvl[m] <= AEL));
    chk({p, "_overflow"},  32'(ovf[m]),  32'(m_ovf[m]));
    chk({p, "_underflow"}, 32'(udf[m]),  32'(m_udf[m]));
    if (m == 0)       chk("std_data_hold", 32'(dout[0]), 32'(m_last));
    else if (m_val[1]) chk("fwft_head",    32'(dout[1]), 32'(mq[1][0]));
  endtask

  // One clock: drive instance m, leave the other idle, then update the model and check both.
  task automatic step(input int m, input bit w, input bit r, input bit c, input logic [23:0] d);
    for (int k = 0; k < 2; k++) begin
      wr_en[k] = (k == m) ? w : 1'b0;
      rd_en[k] = (k == m) ? r : 1'b0;
      clr[k]   = (k == m) ? c : 1'b0;
      din[k]   = (k == m) ? d : 24'h0;
    end
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    check_all(0);
    check_all(1);
  endtask

  task automatic check_reset_values(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_level"},     32'(lvl[m]),  0);
      chk({tag, "_empty"},     32'(empty[m]), 1);
      chk({tag, "_full"},      32'(full[m]), 0);
      chk({tag, "_almost_empty"}, 32'(ae[m]), 1);
      chk({tag, "_almost_full"},  32'(af[m]), 0);
      chk({tag, "_overflow"},  32'(ovf[m]),  0);
      chk({tag, "_underflow"}, 32'(udf[m]),  0);
      chk({tag, "_data_out"},  32'(dout[m]), 0);
    end
  endtask

  int seq;

  initial begin
    rst_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      clr[k] = 0; wr_en[k] = 0; rd_en[k] = 0; din[k] = '0; pend[k] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    check_reset_values("reset");
    seq = 1;

    for (int m = 0; m < 2; m++) begin
      // Fill to full, one rejected write, drain in order.
      for (int i = 1; i <= DEPTH; i++) step(m, 1, 0, 0, 24'(i));
      step(m, 1, 0, 0, 24'h000011);
      for (int i = 0; i < DEPTH; i++) step(m, 0, 1, 0, 24'h0);
      step(m, 0, 0, 0, 24'h0);
      step(m, 0, 0, 1, 24'h0);

      // Read from empty, then a single word through.
      step(m, 0, 1, 0, 24'h0);
      step(m, 1, 0, 0, 24'hABCDEF);
      step(m, 0, 0, 0, 24'h0);
      step(m, 0, 1, 0, 24'h0);
      step(m, 0, 0, 0, 24'h0);
      step(m, 0, 0, 1, 24'h0);

      // Single write seen before any read, then consumed.
      step(m, 1, 0, 0, 24'h123456);
      step(m, 0, 0, 0, 24'h0);
      step(m, 0, 0, 0, 24'h0);
      step(m, 0, 1, 0, 24'h0);
      step(m, 0, 0, 0, 24'h0);

      // Simultaneous read/write at level 8, at full and at empty.
      for (int i = 0; i < 8; i++) begin step(m, 1, 0, 0, 24'(seq)); seq++; end
      for (int i = 0; i < 20; i++) begin step(m, 1, 1, 0, 24'(seq)); seq++; end
      for (int i = 0; i < 8; i++) begin step(m, 1, 0, 0, 24'(seq)); seq++; end
      for (int i = 0; i < 5; i++) begin step(m, 1, 1, 0, 24'(seq)); seq++; end
      step(m, 0, 0, 1, 24'h0);
      for (int i = 0; i < 5; i++) begin step(m, 1, 1, 0, 24'(seq)); seq++; end
      step(m, 0, 0, 1, 24'h0);

      // Level sweeps 0..15 repeatedly to wrap both pointers.
      for (int r = 0; r < 3; r++) begin
        for (int i = 0; i < 15; i++) begin step(m, 1, 0, 0, 24'(seq)); seq++; end
        step(m, 0, 0, 0, 24'h0);
        for (int i = 0; i < 15; i++) step(m, 0, 1, 0, 24'h0);
      end
      step(m, 0, 0, 0, 24'h0);

      // Flush with level 10 and overflow set.
      for (int i = 0; i < DEPTH + 1; i++) begin step(m, 1, 0, 0, 24'(seq)); seq++; end
      for (int i = 0; i < 6; i++) step(m, 0, 1, 0, 24'h0);
      step(m, 0, 0, 1, 24'h0);

      // Randomised traffic with occasional flushes.
      for (int i = 0; i < 300; i++) begin
        step(m, ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
             ($urandom_range(0, 99) < 2), 24'($urandom));
      end
      step(m, 0, 0, 1, 24'h0);
    end

    // Asynchronous reset between edges in the middle of a burst on both instances.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 24'(seq)); seq++;
      step(1, 1, (i > 2), 0, 24'(seq)); seq++;
    end
    for (int k = 0; k < 2; k++) begin wr_en[k] = 1; rd_en[k] = 1; din[k] = 24'h5A5A5A; end
    #2;
    rst_a = 1'b1;
    #1;
    check_reset_values("async_reset");
    for (int k = 0; k < 2; k++) begin wr_en[k] = 0; rd_en[k] = 0; end
    model_reset();
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check_all(0);
    check_all(1);
    for (int i = 0; i < 4; i++) begin step(1, 1, 0, 0, 24'(seq)); seq++; end
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 24'h0);
    for (int i = 0; i < 3; i++) begin step(0, 1, 1, 0, 24'(seq)); seq++; end
    step(0, 0, 1, 0, 24'h0);
    step(0, 0, 0, 0, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
